// File: rtl/io_channel_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_channel_unit_pkg : shared AGC I/O widths and FIFO entry type   | rev 1.0
// ----------------------------------------------------------------------------
package io_channel_unit_pkg;

  localparam int IO_CHAN_W  = 4;
  localparam int AGC_WORD_W = 15;

  typedef struct packed {
    logic [IO_CHAN_W-1:0]  chan;
    logic [AGC_WORD_W-1:0] data;
  } io_entry_t;

endpackage
`default_nettype wire

// File: rtl/io_channel_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_channel_unit_if : core, peripheral-in and peripheral-out channel bus | rev 1.0
// ----------------------------------------------------------------------------
interface io_channel_unit_if;
  import io_channel_unit_pkg::*;

  logic                  IO_write_en;
  logic [IO_CHAN_W-1:0]  IO_write_sel;
  logic [AGC_WORD_W-1:0] IO_write_data;
  logic [IO_CHAN_W-1:0]  IO_read_sel;
  logic [AGC_WORD_W-1:0] IO_read_data;
  logic                  in_valid;
  logic [IO_CHAN_W-1:0]  in_chan;
  logic [AGC_WORD_W-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [IO_CHAN_W-1:0]  out_chan;
  logic [AGC_WORD_W-1:0] out_data;
  logic                  io_full;
  logic                  overflow;

  modport master (
    output IO_write_en, IO_write_sel, IO_write_data, IO_read_sel,
    output in_valid, in_chan, in_data, out_ready,
    input  IO_read_data, out_valid, out_chan, out_data, io_full, overflow
  );

  modport slave (
    input  IO_write_en, IO_write_sel, IO_write_data, IO_read_sel,
    input  in_valid, in_chan, in_data, out_ready,
    output IO_read_data, out_valid, out_chan, out_data, io_full, overflow
  );

endinterface
`default_nettype wire

// File: rtl/io_channel_unit_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo : power-of-two circular FIFO, head read straight from storage | rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   rst_l,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_channel_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_channel_unit : AGC I/O channel register file with core-write output FIFO | rev 1.0
// ----------------------------------------------------------------------------
module io_channel_unit
  import io_channel_unit_pkg::*;
#(
  parameter int NUM_CHAN   = 16,
  parameter int DATA_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              rst_l,
  io_channel_unit_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] chan [NUM_CHAN];
  io_entry_t         push_entry;
  io_entry_t         head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              overflow_flag;

  // Core write is applied last so it wins a same-channel collision.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_CHAN; i++) chan[i] <= '0;
    end else begin
      if (bus.in_valid)    chan[bus.in_chan]      <= bus.in_data;
      if (bus.IO_write_en) chan[bus.IO_write_sel] <= bus.IO_write_data;
    end
  end

  assign bus.IO_read_data = chan[bus.IO_read_sel];

  assign push_entry = '{chan: bus.IO_write_sel, data: bus.IO_write_data};
  assign pop        = bus.out_valid && bus.out_ready;

  sync_fifo #(
    .WIDTH ($bits(io_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_l (rst_l),
    .push  (bus.IO_write_en),
    .pop   (pop),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l)                                        overflow_flag <= 1'b0;
    else if (bus.IO_write_en && fifo_full && !pop)     overflow_flag <= 1'b1;
  end

  assign bus.out_valid = !fifo_empty;
  assign bus.out_chan  = head.chan;
  assign bus.out_data  = head.data;
  assign bus.io_full   = (fifo_count == CW'(FIFO_DEPTH));
  assign bus.overflow  = overflow_flag;

endmodule
`default_nettype wire

// File: doc/io_channel_unit.md
Name: io_channel_unit

Overview:
- Sits directly downstream of the AGC core's writeback I/O port and upstream of its decode-stage I/O read port.
- Holds the 16 I/O channel registers and serves combinational reads to the core.
- Queues every core channel write into an output FIFO, which drains to an external peripheral (DSKY/telemetry) over a valid/ready handshake.
- Accepts asynchronous-source channel updates from a peripheral input port that has already been synchronised.

Parameters:
- NUM_CHAN, 16, number of channel registers; select width is $clog2(NUM_CHAN)=4.
- DATA_W, 15, AGC word width.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of two and ≥2.

Ports:
- clock  in  1  system clock.
- rst_l  in  1  asynchronous, active-low reset.
- IO_write_en  in  1  core writeback write strobe.
- IO_write_sel  in  4  channel written by the core.
- IO_write_data  in  15  data written by the core.
- IO_read_sel  in  4  channel read by core decode.
- IO_read_data  out  15  channel register contents, combinational.
- in_valid  in  1  peripheral update strobe, single cycle, already synchronous.
- in_chan  in  4  channel updated by the peripheral.
- in_data  in  15  peripheral data.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  peripheral accepts head.
- out_chan  out  4  head channel.
- out_data  out  15  head data.
- io_full  out  1  FIFO full; OR'ed into the core stall.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (async, rst_l low):
  - All channel registers clear to 0.
  - FIFO empty: rd_ptr=wr_ptr=count=0.
  - Outputs: out_valid=0, out_chan=0, out_data=0, io_full=0, overflow=0.
  - Reset asserted mid-transfer discards all queued entries; no handshake completes on that edge.
- Reads:
  - IO_read_data = chan[IO_read_sel], combinational, zero latency.
  - A write landing in the same cycle is not bypassed: the read returns the pre-edge value. The core's stall logic covers this hazard.
- Core write (IO_write_en=1), at the clock edge:
  - chan[IO_write_sel] <= IO_write_data.
  - {IO_write_sel, IO_write_data} is pushed into the FIFO.
  - Write-to-visible latency is 1 cycle.
- Peripheral write (in_valid=1):
  - chan[in_chan] <= in_data at the edge.
  - Not pushed to the FIFO.
- Simultaneous writes:
  - Same channel from both sources: the core write wins and the peripheral write is lost.
  - Different channels: both update.
- FIFO:
  - Circular buffer, pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle: allowed when the FIFO is full (the pop frees the slot first, count unchanged) and when it is empty. An empty FIFO has no pop, so count goes 0→1.
- FIFO outputs:
  - out_valid = (count != 0).
  - out_chan/out_data = head entry, driven from storage (registered). They hold stable while out_valid && !out_ready.
- io_full = (count == FIFO_DEPTH), combinational from count.
- Overflow:
  - A push while full with no pop in the same cycle updates the channel register, drops the FIFO entry, and sets overflow.
  - overflow stays set until reset.
- Handshake rule: out_valid, once high, never drops until accepted.

Decomposition:
- Shared package (existing core package): localparams IO_CHAN_W=4, AGC_WORD_W=15, and the typedef io_entry_t = struct packed {logic [3:0] chan; logic [14:0] data;}.
- One sub-module, sync_fifo #(WIDTH, DEPTH), providing push, pop, full, empty, count, head. The top level holds the register file, the write-arbitration logic and the overflow flag.

Test Plan:
- Reset, then a core write of ch3=0o12345 → IO_read_data(sel=3)=0o12345 one cycle later; out_valid=1, out_chan=3, out_data=0o12345; out_ready=1 pops it and out_valid=0 the next cycle.
- Four core writes to ch0..3 with out_ready=0 → io_full=1 after the 4th. A 5th write (ch5=7) → chan[5]=7, FIFO still holds ch0..3 in order, overflow=1. Drain with out_ready=1 → 4 transfers in order ch0,1,2,3.
- FIFO full, simultaneous push (ch6=1) and pop → count stays 4, overflow stays 0, and the last drained entry is ch6=1.
- Same-cycle in_valid ch2=0o777 and core write ch2=0o1 → chan[2]=0o1. Same cycle with in_chan=4 instead → chan[4]=0o777, chan[2]=0o1.
- Hold out_ready=0 for 10 cycles with one entry queued → out_chan/out_data unchanged throughout. Pulse rst_l low asynchronously mid-stream → out_valid=0 immediately, all channels read 0.
- 20 pushes/pops with random out_ready → order preserved across pointer wrap, no overflow while io_full is honoured.
